// File: rtl/scoreboard_unit_pkg.sv
// Shared types for the pipeline scoreboard: slot record, forwarding-select encoding
// and the youngest-producer priority function.
package scoreboard_unit_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        logic     load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    // hit[0] = EX slot, hit[1] = MEM slot, hit[2] = WB slot; the youngest producer wins.
    function automatic fwd_sel_t pick_sel(input logic [2:0] hit, input bit wb_fwd);
        if (hit[0])           return FWD_EXMEM;
        if (hit[1])           return FWD_MEMWB;
        if (hit[2] && wb_fwd) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one in-flight slot against one ID source register.
// Register 0 never matches, and neither does an operand the instruction does not read.
module sb_match
    import scoreboard_unit_pkg::*;
(
    input  sb_slot_t slot,
    input  regbits_t src,
    input  logic     use_src,
    output logic     hit
);

    assign hit = use_src & slot.valid & (src != '0) & (slot.wsel == src);

endmodule

// File: rtl/scoreboard_unit.sv
// Hazard scoreboard beside the ID/EX latch: load-use stall, registered EX forwarding
// selects and a pending-write mask. Define SCOREBOARD_STATS_EN to add stall/flush counters.
module scoreboard_unit
    import scoreboard_unit_pkg::*;
#(
    parameter bit WB_FWD = 1'b1,
    parameter int REGS   = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            pipe_en,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [4:0]      id_wsel,
    input  logic            id_regwen,
    input  logic            id_load,
    output logic            stall,
    output logic [1:0]      fwd_rs,
    output logic [1:0]      fwd_rt,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [REGS-1:0] pending
);

    sb_slot_t ex_s, mem_s, wb_s;
    sb_slot_t slot_vec [3];
    fwd_sel_t fwd_rs_q, fwd_rt_q;
    fwd_sel_t nxt_rs, nxt_rt;
    logic [2:0] hit_rs, hit_rt;
    logic eligible, fwd_bubble;

    assign slot_vec[0] = ex_s;
    assign slot_vec[1] = mem_s;
    assign slot_vec[2] = wb_s;

    for (genvar g = 0; g < 3; g++) begin : g_match
        sb_match u_match_rs (
            .slot    (slot_vec[g]),
            .src     (id_rs),
            .use_src (id_uses_rs),
            .hit     (hit_rs[g])
        );
        sb_match u_match_rt (
            .slot    (slot_vec[g]),
            .src     (id_rt),
            .use_src (id_uses_rt),
            .hit     (hit_rt[g])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall      = 1'b0;
        nxt_rs     = FWD_RF;
        nxt_rt     = FWD_RF;
        eligible   = 1'b0;
        fwd_bubble = 1'b1;
        pending    = '0;

        stall      = id_valid & ~flush & ex_s.valid & ex_s.load & (hit_rs[0] | hit_rt[0]);
        nxt_rs     = pick_sel(hit_rs, WB_FWD);
        nxt_rt     = pick_sel(hit_rt, WB_FWD);
        eligible   = id_valid & id_regwen & (id_wsel != '0);
        // Selects are cleared only when no real instruction enters EX; non-writers
        // such as stores still need forwarded operands.
        fwd_bubble = stall | flush | ~id_valid;

        for (int i = 1; i < REGS; i++) begin
            pending[i] = (ex_s.valid  & (ex_s.wsel  == regbits_t'(i)))
                       | (mem_s.valid & (mem_s.wsel == regbits_t'(i)))
                       | (wb_s.valid  & (wb_s.wsel  == regbits_t'(i)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all slots shift from pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_s     <= SLOT_EMPTY;
            mem_s    <= SLOT_EMPTY;
            wb_s     <= SLOT_EMPTY;
            fwd_rs_q <= FWD_RF;
            fwd_rt_q <= FWD_RF;
        end else if (pipe_en) begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            if (stall || flush || !eligible) begin
                ex_s <= SLOT_EMPTY;
            end else begin
                ex_s <= '{valid: 1'b1, wsel: id_wsel, load: id_load};
            end
            fwd_rs_q <= fwd_bubble ? FWD_RF : nxt_rs;
            fwd_rt_q <= fwd_bubble ? FWD_RF : nxt_rt;
        end
    end

    assign fwd_rs = fwd_rs_q;
    assign fwd_rt = fwd_rt_q;

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && pipe_en && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (flush && pipe_en && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
